// File: rtl/seq_det_if.sv
// Bus bundle for the serial pattern-detector run controller.
// The master side configures, starts and aborts runs and supplies the qualified
// serial bits. The slave side, which is the controller, reports status and hits.
interface seq_det_if #(
  parameter int PAT_W = 4,
  parameter int WIN_W = 16,
  parameter int CNT_W = 8
) ();
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [WIN_W-1:0] cfg_window;
  logic [CNT_W-1:0] cfg_max_hit;
  logic             start;
  logic             abort;
  logic             bit_valid;
  logic             seq_in;
  logic             busy;
  logic             done;
  logic             match;
  logic [CNT_W-1:0] hit_count;
  logic [1:0]       stop_code;

  modport master (
    output cfg_we, cfg_pattern, cfg_window, cfg_max_hit,
           start, abort, bit_valid, seq_in,
    input  busy, done, match, hit_count, stop_code
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_window, cfg_max_hit,
           start, abort, bit_valid, seq_in,
    output busy, done, match, hit_count, stop_code
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Run controller around a programmable overlapping serial pattern detector.
//
// state | meaning
// IDLE  | no run active; config writable; bits ignored
// RUN   | consuming qualified bits, detecting and counting hits
// DONE  | run ended on window end and/or hit limit; results held
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int WIN_W = 16,
  parameter int CNT_W = 8
) (
  input logic     clock,
  input logic     reset,
  seq_det_if.slave bus
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [PAT_W-1:0]  PAT_RST  = PAT_W'(4'b1011);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PAT_W-1:0]  pattern;
  logic [WIN_W-1:0]  window;
  logic [CNT_W-1:0]  max_hit;
  logic [PAT_W-2:0]  hist;
  logic [WIN_W-1:0]  bit_cnt;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  hit_count;
  logic [1:0]        stop_code;
  logic              match;

  logic              bit_ev;
  logic [PAT_W-1:0]  w;
  logic              hit;
  logic [CNT_W:0]    hit_sum;
  logic              win_end;
  logic              lim_end;
  logic [CNT_W-1:0]  hit_count_nxt;
  logic              cfg_open;

  // Per-bit detection and run-termination terms, all evaluated on the current bit.
  always_comb begin
    cfg_open      = (state != RUN);
    bit_ev        = (state == RUN) && bus.bit_valid;
    w             = {hist, bus.seq_in};
    hit           = bit_ev && (fill == FILL_MAX) && (w == pattern);
    hit_sum       = {1'b0, hit_count} + (CNT_W + 1)'(hit);
    lim_end       = bit_ev && (max_hit != '0) && (hit_sum == {1'b0, max_hit});
    win_end       = bit_ev && (window != '0) &&
                    (({1'b0, bit_cnt} + (WIN_W + 1)'(1)) == {1'b0, window});
    hit_count_nxt = (hit && (hit_count != '1)) ? hit_count + CNT_W'(1) : hit_count;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state selection; abort outranks start.
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nxt = RUN;
        RUN:     if (win_end || lim_end) state_nxt = DONE;
        DONE:    if (bus.start) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // Configuration registers, writable only outside a run.
  always_ff @(posedge clock) begin
    if (reset) begin
      pattern <= PAT_RST;
      window  <= '0;
      max_hit <= '0;
    end else if (cfg_open && bus.cfg_we) begin
      pattern <= bus.cfg_pattern;
      window  <= bus.cfg_window;
      max_hit <= bus.cfg_max_hit;
    end
  end

  // Run datapath: shift history, count bits and hits, register match and stop reason.
  always_ff @(posedge clock) begin
    if (reset) begin
      hist      <= '0;
      bit_cnt   <= '0;
      fill      <= '0;
      hit_count <= '0;
      stop_code <= 2'b00;
      match     <= 1'b0;
    end else begin
      match <= 1'b0;
      if (bus.abort) begin
        stop_code <= 2'b00;
      end else if (cfg_open && bus.start) begin
        hist      <= '0;
        bit_cnt   <= '0;
        fill      <= '0;
        hit_count <= '0;
        stop_code <= 2'b00;
      end else if (bit_ev) begin
        hist      <= w[PAT_W-2:0];
        bit_cnt   <= bit_cnt + WIN_W'(1);
        fill      <= (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
        match     <= hit;
        hit_count <= hit_count_nxt;
        if (win_end || lim_end) stop_code <= {lim_end, win_end};
      end
    end
  end

  assign bus.match     = match;
  assign bus.hit_count = hit_count;
  assign bus.stop_code = stop_code;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios with literal
// expectations, then randomized traffic, all compared cycle by cycle against
// a queue-based behavioural model.
module tb_seq_det_ctrl;
  localparam int P = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  seq_det_if #(.PAT_W(4), .WIN_W(16), .CNT_W(8)) bus ();

  seq_det_ctrl #(.PAT_W(4), .WIN_W(16), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the run's bits are kept in a queue and the last P are
  // compared with the pattern directly.
  bit       m_valid = 0;
  bit       m_run, m_done, m_match;
  int       m_hits;
  bit [1:0] m_stop;
  bit [3:0] m_pat;
  int       m_win, m_max;
  bit       q[$];

  always @(posedge clock) begin
    bit pre_run, h, wn, lm;
    int nb;
    pre_run = m_run;
    if (reset) begin
      m_valid = 1; m_run = 0; m_done = 0; m_match = 0;
      q.delete(); m_hits = 0; m_stop = 0;
      m_pat = 4'b1011; m_win = 0; m_max = 0;
    end else begin
      m_match = 0;
      if (bus.abort) begin
        m_run = 0; m_done = 0; m_stop = 0;
      end else if (!m_run && bus.start) begin
        m_run = 1; m_done = 0; q.delete(); m_hits = 0; m_stop = 0;
      end else if (m_run && bus.bit_valid) begin
        q.push_back(bus.seq_in);
        nb = q.size();
        h = 0;
        if (nb >= P) begin
          h = 1;
          for (int k = 0; k < P; k++)
            if (q[nb-P+k] != m_pat[P-1-k]) h = 0;
        end
        wn = (m_win != 0) && (nb == m_win);
        lm = (m_max != 0) && ((m_hits + int'(h)) == m_max);
        if (h && m_hits < 255) m_hits++;
        m_match = h;
        if (wn || lm) begin
          m_run = 0; m_done = 1; m_stop = {lm, wn};
        end
      end
      if (!pre_run && bus.cfg_we) begin
        m_pat = bus.cfg_pattern;
        m_win = int'(bus.cfg_window);
        m_max = int'(bus.cfg_max_hit);
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (m_valid) begin
      check("busy",      int'(bus.busy),      int'(m_run));
      check("done",      int'(bus.done),      int'(m_done));
      check("match",     int'(bus.match),     int'(m_match));
      check("hit_count", int'(bus.hit_count), m_hits);
      check("stop_code", int'(bus.stop_code), int'(m_stop));
    end
  end

  task automatic do_cfg(input logic [3:0] p, input int win, input int mh);
    bus.cfg_pattern = p;
    bus.cfg_window  = 16'(win);
    bus.cfg_max_hit = 8'(mh);
    bus.cfg_we      = 1'b1;
    @(negedge clock);
    bus.cfg_we      = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send(input bit b, input int gap);
    bus.bit_valid = 1'b0;
    repeat (gap) @(negedge clock);
    bus.bit_valid = 1'b1;
    bus.seq_in    = b;
    @(negedge clock);
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [15:0] s, input int n, input int maxgap);
    for (int i = n - 1; i >= 0; i--)
      send(s[i], (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0);
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_pattern = 0; bus.cfg_window = 0; bus.cfg_max_hit = 0;
    bus.start = 0; bus.abort = 0; bus.bit_valid = 0; bus.seq_in = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_hc",   int'(bus.hit_count), 0);

    // T1: continuous 1011011, unlimited run
    do_start();
    send(1, 0); send(0, 0); send(1, 0);
    check("t1_no_early_match", int'(bus.match), 0);
    send(1, 0);
    check("t1_match_bit4", int'(bus.match), 1);
    send(0, 0);
    check("t1_match_off", int'(bus.match), 0);
    send(1, 0); send(1, 0);
    check("t1_match_bit7", int'(bus.match), 1);
    check("t1_hc", int'(bus.hit_count), 2);
    check("t1_busy", int'(bus.busy), 1);

    // T2: window of 8 bits
    do_abort();
    do_cfg(4'b1011, 8, 0);
    do_start();
    send_stream(16'b10111011, 8, 0);
    check("t2_done", int'(bus.done), 1);
    check("t2_busy", int'(bus.busy), 0);
    check("t2_stop", int'(bus.stop_code), 1);
    check("t2_hc",   int'(bus.hit_count), 2);
    send_stream(16'b1011, 4, 0);
    check("t2_ignored_hc", int'(bus.hit_count), 2);

    // T3: hit limit of 1
    do_cfg(4'b1011, 0, 1);
    do_start();
    send_stream(16'b1011, 4, 0);
    check("t3_done", int'(bus.done), 1);
    check("t3_stop", int'(bus.stop_code), 2);
    check("t3_hc",   int'(bus.hit_count), 1);
    send_stream(16'b011, 3, 0);
    check("t3_no_match", int'(bus.match), 0);
    check("t3_hc_held",  int'(bus.hit_count), 1);

    // T4: gapped stream, then cleared history with pattern 0001
    do_cfg(4'b1011, 0, 0);
    do_start();
    send_stream(16'b1011011, 7, 3);
    check("t4_hc",   int'(bus.hit_count), 2);
    check("t4_busy", int'(bus.busy), 1);
    do_abort();
    do_cfg(4'b0001, 0, 0);
    do_start();
    send(1, 0);
    check("t4_first_bit_no_hit", int'(bus.match), 0);
    send_stream(16'b0001, 4, 0);
    check("t4_0001_hit", int'(bus.match), 1);
    check("t4_0001_hc",  int'(bus.hit_count), 1);

    // T5: config write ignored during run, abort holds hit_count
    do_abort();
    do_cfg(4'b1011, 0, 0);
    do_start();
    do_cfg(4'b0000, 0, 0);
    send_stream(16'b0000, 4, 0);
    check("t5_cfg_ignored", int'(bus.hit_count), 0);
    send_stream(16'b1011, 4, 0);
    check("t5_hc", int'(bus.hit_count), 1);
    do_abort();
    check("t5_abort_busy", int'(bus.busy), 0);
    check("t5_abort_done", int'(bus.done), 0);
    check("t5_abort_hc",   int'(bus.hit_count), 1);

    // T6: window and limit on the same bit, then reset mid-run
    do_cfg(4'b1011, 4, 1);
    do_start();
    send_stream(16'b1011, 4, 0);
    check("t6_stop_both", int'(bus.stop_code), 3);
    check("t6_done",      int'(bus.done), 1);
    do_start();
    send_stream(16'b10, 2, 0);
    do_reset();
    check("t6_rst_busy",  int'(bus.busy), 0);
    check("t6_rst_done",  int'(bus.done), 0);
    check("t6_rst_match", int'(bus.match), 0);
    check("t6_rst_hc",    int'(bus.hit_count), 0);
    check("t6_rst_stop",  int'(bus.stop_code), 0);
    do_start();
    send_stream(16'b1011, 4, 0);
    check("t6_default_pattern", int'(bus.match), 1);
    check("t6_no_window",       int'(bus.busy), 1);

    // Saturation of hit_count
    do_abort();
    do_cfg(4'b1111, 0, 0);
    do_start();
    for (int i = 0; i < 262; i++) send(1, 0);
    check("sat_hc",   int'(bus.hit_count), 255);
    check("sat_busy", int'(bus.busy), 1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset           = ($urandom_range(0, 399) == 0);
      bus.cfg_we      = ($urandom_range(0, 11) == 0);
      bus.cfg_pattern = 4'($urandom);
      bus.cfg_window  = 16'($urandom_range(0, 14));
      bus.cfg_max_hit = 8'($urandom_range(0, 4));
      bus.start       = ($urandom_range(0, 15) == 0);
      bus.abort       = ($urandom_range(0, 79) == 0);
      bus.bit_valid   = ($urandom_range(0, 2) != 0);
      bus.seq_in      = 1'($urandom);
      @(negedge clock);
    end
    reset = 0; bus.cfg_we = 0; bus.start = 0; bus.abort = 0; bus.bit_valid = 0;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
